uc_queue_mp: RTL and testbench
==============================

UC_QUEUE_MP -- requirements
Module: uc_queue_mp

Interface
REQ-001 Parameter DEPTH, default 16: queue entries; power of two, >= 2*NUM_PUSH.
REQ-002 Parameter NUM_PUSH, default 2: number of independent push channels.
REQ-003 Parameter LIT_W, default $clog2(`LIT_IDX_MAX)+1: literal width; MSB = polarity (1 = negated), lower bits = variable index.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  clear queue and sticky flags without reset.
REQ-007 push  input  NUM_PUSH  per-channel push request.
REQ-008 uca2ucq  input  NUM_PUSH x LIT_W  per-channel literal.
REQ-009 pop  input  1  consume head literal.
REQ-010 ucq2eng  output  LIT_W  head literal (show-ahead); 0 when empty.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count > DEPTH-NUM_PUSH (cannot guarantee a full push set).
REQ-013 count  output  $clog2(DEPTH+1)  valid entries.
REQ-014 conflict  output  1  sticky: a literal and its complement were both enqueued/pending.
REQ-015 conflict_var  output  LIT_W-1  variable index of the first detected conflict.
REQ-016 overflow  output  1  sticky: a push set was presented while full.

Function
REQ-017 A push request with variable index 0 shall be ignored (null literal).
REQ-018 When full=1, all pushes in that cycle shall be dropped and overflow set; no partial acceptance.
REQ-019 When full=0, valid pushes shall be written in channel order 0..NUM_PUSH-1 to consecutive tail slots in the same edge.
REQ-020 A push equal to any valid entry (incl. head being popped this cycle) or to a lower-indexed push in the same cycle shall be dropped as duplicate; no slot consumed.
REQ-021 A push whose complement matches a valid entry or any other same-cycle push shall set conflict; the literal shall still be enqueued.
REQ-022 On multiple conflicts in one cycle, conflict_var shall capture the lowest channel's variable; later conflicts shall not overwrite until flush/reset.
REQ-023 pop with empty=0 shall advance head by one; pop with empty=1 shall be ignored, no state change.
REQ-024 Simultaneous push and pop: count_next = count + accepted_pushes - popped; full/empty evaluated on pre-edge count.
REQ-025 Head/tail pointers shall wrap modulo DEPTH; count distinguishes full from empty.
REQ-026 ucq2eng, empty, full, count shall reflect the registered state combinationally; a pushed literal appears at ucq2eng no earlier than the cycle after its push edge.
REQ-027 flush shall take priority over push and pop in the same cycle: next state empty, conflict/overflow/conflict_var cleared.

Reset
REQ-028 rst=1 at a rising edge shall force count=0, head=tail=0, conflict=0, conflict_var=0, overflow=0, ignoring push/pop/flush.
REQ-029 Entry storage need not be cleared; ucq2eng shall read 0 while empty.
REQ-030 Reset asserted mid-operation shall discard all entries in one cycle; operation resumes the cycle after rst deasserts.

Structure
REQ-031 Package ucq_pkg shall hold LIT_W, typedef lit_t, and function lit_neg (flip MSB) shared with assignment and engine blocks.
REQ-032 Sub-module ucq_cam_match shall compare one literal against all entries under the valid mask, returning same_hit and comp_hit; instantiated NUM_PUSH times.
REQ-033 Valid mask derived from head and count; no per-entry valid flops required.

Verification (DEPTH=8, NUM_PUSH=2, LIT_W=8)
REQ-034 Reset, push ch0=0x02 then 0x04,0x06 singly -> count=3, ucq2eng=0x02; pop -> ucq2eng=0x04, count=2.
REQ-035 Same-cycle ch0=0x0A, ch1=0x0A -> count +1 only; later push 0x0A again -> dropped, count unchanged.
REQ-036 Queue holds 0x03; push 0x83 -> conflict=1, conflict_var=3, count +1; flush -> conflict=0, empty=1.
REQ-037 Fill to count=7 (full=1); push ch0=0x11, ch1=0x12 -> both dropped, overflow=1, count=7.
REQ-038 Wrap: push/pop 20 distinct literals with simultaneous push+pop each cycle -> FIFO order preserved across pointer wrap, count constant.
REQ-039 Pop while empty -> no change, ucq2eng=0; rst mid-fill (count=5) -> next cycle count=0, flags 0.

Source files
------------

// File: rtl/ucq_pkg.sv
// Shared literal definitions for the unit-clause queue and the blocks around it.
// A literal is a polarity bit (MSB, 1 = negated) above a variable index.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 127
`endif

package ucq_pkg;

  localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;

  typedef logic [LIT_W-1:0] lit_t;

  function automatic lit_t lit_neg(input lit_t l);
    return {~l[LIT_W-1], l[LIT_W-2:0]};
  endfunction

endpackage

// File: rtl/ucq_cam_match.sv
// Compares one literal against every queue entry under the valid mask and
// reports an exact hit and a complement hit.
module ucq_cam_match
  import ucq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LIT_W = 8
) (
  input  logic [LIT_W-1:0]            lit,
  input  logic [DEPTH-1:0][LIT_W-1:0] entries,
  input  logic [DEPTH-1:0]            valid_mask,
  output logic                        same_hit,
  output logic                        comp_hit
);

  logic [LIT_W-1:0] comp;

  always_comb begin
    comp     = {~lit[LIT_W-1], lit[LIT_W-2:0]};
    same_hit = 1'b0;
    comp_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      same_hit = same_hit | (valid_mask[i] & (entries[i] == lit));
      comp_hit = comp_hit | (valid_mask[i] & (entries[i] == comp));
    end
  end

endmodule

// File: rtl/uc_queue_mp.sv
// Multi-push unit-clause queue: deduplicating circular FIFO of literals with
// sticky conflict (literal and complement both queued) and overflow flags.
module uc_queue_mp
  import ucq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_PUSH = 2,
  parameter int LIT_W    = ucq_pkg::LIT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_PUSH-1:0]             push,
  input  logic [NUM_PUSH-1:0][LIT_W-1:0]  uca2ucq,
  input  logic                            pop,
  output logic [LIT_W-1:0]                ucq2eng,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            conflict,
  output logic [LIT_W-2:0]                conflict_var,
  output logic                            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][LIT_W-1:0] mem;
  logic [PW-1:0]               head;
  logic [PW-1:0]               tail;
  logic [DEPTH-1:0]            valid_mask;
  logic [PW-1:0]               mask_off;

  logic [NUM_PUSH-1:0]         req_valid;
  logic [NUM_PUSH-1:0]         same_hit;
  logic [NUM_PUSH-1:0]         comp_hit;
  logic [NUM_PUSH-1:0]         dup_pend;
  logic [NUM_PUSH-1:0]         pair_comp;
  logic [NUM_PUSH-1:0]         accept;
  logic [NUM_PUSH-1:0]         conf;
  logic [NUM_PUSH-1:0][PW-1:0] wr_idx;
  logic [PW-1:0]               ofs;
  logic [CW-1:0]               n_acc;
  logic                        conf_found;
  logic [LIT_W-2:0]            conf_sel;
  logic                        pop_ok;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count > CW'(DEPTH - NUM_PUSH));
  assign pop_ok  = pop & ~empty;
  assign ucq2eng = empty ? {LIT_W{1'b0}} : mem[head];

  // An entry is live when its distance from head is below count.
  always_comb begin
    mask_off   = {PW{1'b0}};
    valid_mask = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      mask_off      = PW'(i) - head;
      valid_mask[i] = (CW'(mask_off) < count);
    end
  end

  for (genvar g = 0; g < NUM_PUSH; g++) begin : g_cam
    ucq_cam_match #(.DEPTH(DEPTH), .LIT_W(LIT_W)) u_cam (
      .lit        (uca2ucq[g]),
      .entries    (mem),
      .valid_mask (valid_mask),
      .same_hit   (same_hit[g]),
      .comp_hit   (comp_hit[g])
    );
  end

  // Per-channel accept/conflict decisions and packed tail slot assignment.
  always_comb begin
    req_valid  = {NUM_PUSH{1'b0}};
    dup_pend   = {NUM_PUSH{1'b0}};
    pair_comp  = {NUM_PUSH{1'b0}};
    accept     = {NUM_PUSH{1'b0}};
    conf       = {NUM_PUSH{1'b0}};
    wr_idx     = '0;
    ofs        = {PW{1'b0}};
    n_acc      = {CW{1'b0}};
    conf_found = 1'b0;
    conf_sel   = {(LIT_W-1){1'b0}};
    for (int p = 0; p < NUM_PUSH; p++) begin
      req_valid[p] = push[p] & (uca2ucq[p][LIT_W-2:0] != {(LIT_W-1){1'b0}});
    end
    for (int p = 0; p < NUM_PUSH; p++) begin
      for (int q = 0; q < NUM_PUSH; q++) begin
        dup_pend[p]  = dup_pend[p] | ((q < p) & req_valid[q] & (uca2ucq[q] == uca2ucq[p]));
        pair_comp[p] = pair_comp[p] | ((q != p) & req_valid[q] &
                       (uca2ucq[q] == {~uca2ucq[p][LIT_W-1], uca2ucq[p][LIT_W-2:0]}));
      end
      accept[p] = req_valid[p] & ~full & ~same_hit[p] & ~dup_pend[p];
      conf[p]   = req_valid[p] & ~full & (comp_hit[p] | pair_comp[p]);
      wr_idx[p] = tail + ofs;
      ofs       = ofs + PW'(accept[p]);
      n_acc     = n_acc + CW'(accept[p]);
      if (conf[p] && !conf_found) begin
        conf_found = 1'b1;
        conf_sel   = uca2ucq[p][LIT_W-2:0];
      end else begin
        conf_found = conf_found;
      end
    end
  end

  // Entry storage is never reset; empty masks the head output instead.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PUSH; p++) begin
      if (!rst && !flush && accept[p]) begin
        mem[wr_idx[p]] <= uca2ucq[p];
      end
    end
  end

  // Pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head         <= {PW{1'b0}};
      tail         <= {PW{1'b0}};
      count        <= {CW{1'b0}};
      conflict     <= 1'b0;
      conflict_var <= {(LIT_W-1){1'b0}};
      overflow     <= 1'b0;
    end else begin
      head  <= head + PW'(pop_ok);
      tail  <= tail + ofs;
      count <= count + n_acc - CW'(pop_ok);
      if (conf_found && !conflict) begin
        conflict     <= 1'b1;
        conflict_var <= conf_sel;
      end
      if (full && (|req_valid)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uc_queue_mp.sv
// Directed bench for uc_queue_mp (DEPTH=8, NUM_PUSH=2, LIT_W=8): expected pop
// order is queued by the stimulus and checked by an independent monitor.
module tb_uc_queue_mp;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [1:0]      push;
  logic [1:0][7:0] uca2ucq;
  logic            pop;
  logic [7:0]      ucq2eng;
  logic            empty;
  logic            full;
  logic [3:0]      count;
  logic            conflict;
  logic [6:0]      conflict_var;
  logic            overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uc_queue_mp #(.DEPTH(8), .NUM_PUSH(2), .LIT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .uca2ucq      (uca2ucq),
    .pop          (pop),
    .ucq2eng      (ucq2eng),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .conflict     (conflict),
    .conflict_var (conflict_var),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected literal.
  always @(negedge clk) begin
    if (!rst && !flush && pop) begin
      if (!empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no entry", ucq2eng);
        end else begin
          chk("pop_head", {24'd0, ucq2eng}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        chk("pop_empty_out", {24'd0, ucq2eng}, 32'd0);
      end
    end
  end

  task automatic cyc(input logic [1:0] p, input logic [7:0] l0, input logic [7:0] l1,
                     input logic pp);
    push       = p;
    uca2ucq[0] = l0;
    uca2ucq[1] = l1;
    pop        = pp;
    @(posedge clk);
    #1;
    push = 2'b00;
    pop  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    push    = 2'b00;
    uca2ucq = '0;
    pop     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out", 32'(ucq2eng), 32'd0);
    chk("rst_flags", {29'd0, conflict, overflow, |conflict_var}, 32'd0);

    // Single pushes then a pop
    exp_q.push_back(8'h02); cyc(2'b01, 8'h02, 8'h00, 1'b0);
    exp_q.push_back(8'h04); cyc(2'b01, 8'h04, 8'h00, 1'b0);
    exp_q.push_back(8'h06); cyc(2'b01, 8'h06, 8'h00, 1'b0);
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_head", 32'(ucq2eng), 32'h02);
    cyc(2'b00, 8'h00, 8'h00, 1'b1);
    chk("pop1_head", 32'(ucq2eng), 32'h04);
    chk("pop1_count", 32'(count), 32'd2);
    cyc(2'b00, 8'h00, 8'h00, 1'b1);
    cyc(2'b00, 8'h00, 8'h00, 1'b1);
    chk("drain_empty", 32'(empty), 32'd1);

    // Duplicates: same cycle and against a stored entry
    exp_q.push_back(8'h0A); cyc(2'b11, 8'h0A, 8'h0A, 1'b0);
    chk("dup_same_cycle", 32'(count), 32'd1);
    cyc(2'b10, 8'h00, 8'h0A, 1'b0);
    chk("dup_stored", 32'(count), 32'd1);
    // Null literals are ignored regardless of polarity
    cyc(2'b11, 8'h80, 8'h00, 1'b0);
    chk("null_ignored", 32'(count), 32'd1);
    // Push equal to the head being popped is a duplicate
    cyc(2'b01, 8'h0A, 8'h00, 1'b1);
    chk("dup_popped_head", 32'(count), 32'd0);

    // Conflicts against stored and same-cycle literals
    exp_q.push_back(8'h03); cyc(2'b01, 8'h03, 8'h00, 1'b0);
    exp_q.push_back(8'h83); cyc(2'b01, 8'h83, 8'h00, 1'b0);
    chk("conf_flag", 32'(conflict), 32'd1);
    chk("conf_var", 32'(conflict_var), 32'd3);
    chk("conf_count", 32'(count), 32'd2);
    do_flush();
    chk("flush_conf", 32'(conflict), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_var", 32'(conflict_var), 32'd0);
    exp_q.push_back(8'h05); exp_q.push_back(8'h85);
    cyc(2'b11, 8'h05, 8'h85, 1'b0);
    chk("pair_conf_var", 32'(conflict_var), 32'd5);
    chk("pair_conf_count", 32'(count), 32'd2);
    exp_q.push_back(8'h87); exp_q.push_back(8'h07);
    cyc(2'b11, 8'h87, 8'h07, 1'b0);
    chk("conf_var_sticky", 32'(conflict_var), 32'd5);
    chk("conf_count4", 32'(count), 32'd4);
    do_flush();

    // Fill to full, then an overflowing push set
    exp_q.push_back(8'h21); exp_q.push_back(8'h22); cyc(2'b11, 8'h21, 8'h22, 1'b0);
    exp_q.push_back(8'h23); exp_q.push_back(8'h24); cyc(2'b11, 8'h23, 8'h24, 1'b0);
    exp_q.push_back(8'h25); exp_q.push_back(8'h26); cyc(2'b11, 8'h25, 8'h26, 1'b0);
    chk("count6_not_full", 32'(full), 32'd0);
    exp_q.push_back(8'h27); cyc(2'b01, 8'h27, 8'h00, 1'b0);
    chk("full_count", 32'(count), 32'd7);
    chk("full_flag", 32'(full), 32'd1);
    cyc(2'b11, 8'h11, 8'h12, 1'b0);
    chk("ovf_count", 32'(count), 32'd7);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (7) cyc(2'b00, 8'h00, 8'h00, 1'b1);
    chk("ovf_drained", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    chk("flush_ovf", 32'(overflow), 32'd0);

    // Steady push+pop across pointer wrap
    exp_q.push_back(8'h30); exp_q.push_back(8'h31); cyc(2'b11, 8'h30, 8'h31, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h32 + 8'(i));
      cyc(2'b01, 8'h32 + 8'(i), 8'h00, 1'b1);
      if (count != 4'd2) begin
        chk("wrap_count", 32'(count), 32'd2);
      end
    end
    chk("wrap_count_end", 32'(count), 32'd2);
    chk("wrap_head", 32'(ucq2eng), 32'h44);
    repeat (2) cyc(2'b00, 8'h00, 8'h00, 1'b1);

    // Pop while empty, then reset mid-fill
    cyc(2'b00, 8'h00, 8'h00, 1'b1);
    chk("empty_pop_count", 32'(count), 32'd0);
    exp_q.push_back(8'h61); exp_q.push_back(8'hE1); cyc(2'b11, 8'h61, 8'hE1, 1'b0);
    exp_q.push_back(8'h62); exp_q.push_back(8'h63); cyc(2'b11, 8'h62, 8'h63, 1'b0);
    exp_q.push_back(8'h64); cyc(2'b01, 8'h64, 8'h00, 1'b0);
    chk("mid_count", 32'(count), 32'd5);
    chk("mid_conf", 32'(conflict), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_flags", {30'd0, conflict, overflow}, 32'd0);
    chk("midrst_var", 32'(conflict_var), 32'd0);
    chk("midrst_out", 32'(ucq2eng), 32'd0);
    exp_q.push_back(8'h70); cyc(2'b01, 8'h70, 8'h00, 1'b0);
    chk("resume_head", 32'(ucq2eng), 32'h70);
    cyc(2'b00, 8'h00, 8'h00, 1'b1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
